// File: rtl/uart_top.sv
// Single-channel UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
// Build option: UART_TOP_BACK2BACK_EN lets a request made during the stop bit start the next frame with no idle gap.
module uart_top #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_ENABLE,
  input  logic                  PAR_TYPE,
  output logic                  S_DATA,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  s_data_q, s_data_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  // state_q names the bit currently on the line; s_data_d is the bit of the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    s_data_d   = s_data_q;
    busy_d     = busy_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        s_data_d = 1'b1;
        if (DATA_VALID) accept = 1'b1;
      end
      START: begin
        state_d  = DATA;
        cnt_d    = '0;
        s_data_d = data_q[0];
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d  = PARITY;
            s_data_d = par_type_q ? ~^data_q : ^data_q;
          end else begin
            state_d  = STOP;
            s_data_d = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          s_data_d = data_q[cnt_d];
        end
      end
      PARITY: begin
        state_d  = STOP;
        s_data_d = 1'b1;
      end
      STOP: begin
        state_d  = IDLE;
        s_data_d = 1'b1;
        busy_d   = 1'b0;
`ifdef UART_TOP_BACK2BACK_EN
        if (DATA_VALID) accept = 1'b1;
`endif
      end
      default: begin
        state_d  = IDLE;
        s_data_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase

    // Acceptance latches the frame settings and drives the start bit at the same edge
    if (accept) begin
      state_d    = START;
      data_d     = P_DATA;
      par_en_d   = PAR_ENABLE;
      par_type_d = PAR_TYPE;
      cnt_d      = '0;
      s_data_d   = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      s_data_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      s_data_q   <= s_data_d;
      busy_q     <= busy_d;
    end
  end

  assign S_DATA = s_data_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: frame table plus hand sequences; expected line bits queued at drive time, popped per busy cycle.
module tb_uart_top;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ENABLE;
  logic       PAR_TYPE;
  logic       S_DATA;
  logic       BUSY;

`ifdef UART_TOP_BACK2BACK_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptype;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[9];
  logic exp_q[$];
  logic e;
  bit   mon_en;
  int   n_cmp;
  int   n_fail;

  uart_top #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ENABLE(PAR_ENABLE),
    .PAR_TYPE  (PAR_TYPE),
    .S_DATA    (S_DATA),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // Drive one request, scramble the inputs after acceptance, optionally inject a request at busy cycle `inject`
  task automatic send(input logic [7:0] d, input logic pen, input logic ptype,
                      input logic exp_par, input int exp_len, input int inject);
    int cnt;
    @(negedge CLK); #1;
    P_DATA = d; PAR_ENABLE = pen; PAR_TYPE = ptype; DATA_VALID = 1'b1;
    push_frame(d, pen, exp_par);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0; P_DATA = ~d; PAR_ENABLE = ~pen; PAR_TYPE = ~ptype;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK); #1;
      if (!BUSY) break;
      cnt++;
      if (inject >= 0 && cnt == inject) begin
        P_DATA = 8'h3C; DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    DATA_VALID = 1'b0;
    chk("busy_len", 32'(cnt), 32'(exp_len));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: every busy cycle consumes one expected bit, idle cycles must show 1
  always @(negedge CLK) begin
    if (mon_en) begin
      if (BUSY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_bit: S_DATA=%0b with no bit expected at %0t", S_DATA, $time);
        end else begin
          e = exp_q.pop_front();
          chk("s_data_bit", 32'(S_DATA), 32'(e));
        end
      end else begin
        chk("idle_line", 32'(S_DATA), 32'd1);
      end
    end
  end

  initial begin
    int g;
    bit seen;
    n_cmp = 0; n_fail = 0; mon_en = 1'b0;
    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_ENABLE = 1'b0; PAR_TYPE = 1'b0;

    vecs[0] = '{8'hAB, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{8'hAB, 1'b1, 1'b0, 1'b1, 11};
    vecs[2] = '{8'hAB, 1'b1, 1'b1, 1'b0, 11};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 10};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
    vecs[8] = '{8'h80, 1'b1, 1'b1, 1'b0, 11};

    // Reset state and release
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_s_data", 32'(S_DATA), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b1;
    @(negedge CLK); #1;
    chk("post_rst_s_data", 32'(S_DATA), 32'd1);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++)
      send(vecs[i].data, vecs[i].pen, vecs[i].ptype, vecs[i].exp_par, vecs[i].exp_len, -1);

    // Mid-frame request and data change during bit 4 must be dropped
    send(8'hAB, 1'b1, 1'b0, 1'b1, 11, 6);
    repeat (3) @(negedge CLK);
    #1;
    chk("dropped_req_busy", 32'(BUSY), 32'd0);

    // DATA_VALID held across two frames
    @(negedge CLK); #1;
    P_DATA = 8'h55; PAR_ENABLE = 1'b0; PAR_TYPE = 1'b0; DATA_VALID = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'hC3, 1'b0, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'hC3;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK); #1;
      if (exp_q.size() == 10) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("b2b_first_frame");
    g = 0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      if (exp_q.size() == 9) begin seen = 1'b1; break; end
      g++;
    end
    DATA_VALID = 1'b0;
    if (!seen) fail_now("b2b_second_start");
    chk("b2b_gap", 32'(g), 32'(EXP_GAP));
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK); #1;
      if (!BUSY) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("b2b_busy_fall");
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge CLK);
    #1;
    chk("b2b_idle_after", 32'(BUSY), 32'd0);

    // Asynchronous reset mid-frame
    @(negedge CLK); #1;
    P_DATA = 8'hAB; PAR_ENABLE = 1'b1; PAR_TYPE = 1'b0; DATA_VALID = 1'b1;
    push_frame(8'hAB, 1'b1, 1'b1);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    chk("pre_abort_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    #1;
    chk("abort_s_data", 32'(S_DATA), 32'd1);
    chk("abort_busy", 32'(BUSY), 32'd0);
    exp_q.delete();
    @(negedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK); #1;
    chk("abort_stays_idle", 32'(BUSY), 32'd0);

    // Clean frame after the abort
    send(8'hAB, 1'b1, 1'b1, 1'b0, 11, -1);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
